// File: rtl/shift_add_mul_seq.sv
// Sequential unsigned shift-and-add multiplier: one conditional add plus shift per clock.
// Optional early termination is enabled by defining SHIFT_ADD_MUL_EARLY_TERM_EN.
module shift_add_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [CNT_W-1:0]     iter
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] WIDE_ZERO = {(2*WIDTH){1'b0}};
  localparam logic [WIDTH-1:0]   OP_ZERO   = {WIDTH{1'b0}};

  state_t               state_r, state_nxt_s;
  logic [2*WIDTH-1:0]   acc_r, acc_nxt_s;
  logic [2*WIDTH-1:0]   mcand_r, mcand_nxt_s;
  logic [WIDTH-1:0]     mplier_r, mplier_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0]     iter_r, iter_nxt_s;
  logic [2*WIDTH-1:0]   product_r, product_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 done_r, done_nxt_s;
  logic [2*WIDTH-1:0]   add_term_s;

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt_s  = state_r;
    acc_nxt_s    = acc_r;
    mcand_nxt_s  = mcand_r;
    mplier_nxt_s = mplier_r;
    cnt_nxt_s    = cnt_r;
    iter_nxt_s   = iter_r;
    add_term_s   = WIDE_ZERO;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          acc_nxt_s    = WIDE_ZERO;
          mcand_nxt_s  = {OP_ZERO, a};
          mplier_nxt_s = b;
          cnt_nxt_s    = CNT_ZERO;
          iter_nxt_s   = CNT_ZERO;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
          if (b == OP_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
`else
          state_nxt_s  = ST_RUN;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (mplier_r[0]) begin
          add_term_s = mcand_r;
        end else begin
          add_term_s = WIDE_ZERO;
        end
        // Unsigned product always fits in 2*WIDTH bits, so the carry out is dropped.
        acc_nxt_s    = acc_r + add_term_s;
        mcand_nxt_s  = mcand_r << 1;
        mplier_nxt_s = mplier_r >> 1;
        cnt_nxt_s    = cnt_r + CNT_ONE;
        iter_nxt_s   = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        end else if ((mplier_r >> 1) == OP_ZERO) begin
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_RUN;
        end
      end

      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output values derived from the next state so busy/done/product come straight from flops.
  always_comb begin
    busy_nxt_s = (state_nxt_s == ST_RUN);
    done_nxt_s = (state_nxt_s == ST_DONE);
    if (state_nxt_s == ST_DONE) begin
      product_nxt_s = acc_nxt_s;
    end else begin
      product_nxt_s = product_r;
    end
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      acc_r     <= WIDE_ZERO;
      mcand_r   <= WIDE_ZERO;
      mplier_r  <= OP_ZERO;
      cnt_r     <= CNT_ZERO;
      iter_r    <= CNT_ZERO;
      product_r <= WIDE_ZERO;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      acc_r     <= acc_nxt_s;
      mcand_r   <= mcand_nxt_s;
      mplier_r  <= mplier_nxt_s;
      cnt_r     <= cnt_nxt_s;
      iter_r    <= iter_nxt_s;
      product_r <= product_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;
  assign iter    = iter_r;

endmodule
